// File: rtl/dma_rx_packer_if.sv
// ---------------------------------------------------------------------------
// dma_rx_packer_if
//   Bundles the completion-beat input side and the packed-word output side
//   of dma_rx_packer into one interface.
//
//   Beat side (driven by the RX endpoint):
//     packer_dout      beat data, DW lane k = bits [32k+31:32k]
//     packer_first_dw  lowest valid lane; lanes first_dw..3 carry data
//     packer_valid     beat strobe
//     packer_done      last beat of a completion transfer
//   Word side (towards the DMA write engine):
//     o_data/o_keep/o_last  head word of the output FIFO
//     o_valid / i_ready     show-ahead handshake
//     o_overflow            sticky: a word was dropped on a full FIFO
//     o_proto_err           sticky: a beat arrived during a flush cycle
//     o_xfer_cnt            completed transfers, wrapping
//
//   Modports: slave = packer view, master = environment view.
// ---------------------------------------------------------------------------
interface dma_rx_packer_if #(
  parameter int P_DATA_WIDTH = 128
);
  logic [P_DATA_WIDTH-1:0] packer_dout;
  logic [1:0]              packer_first_dw;
  logic                    packer_valid;
  logic                    packer_done;
  logic [P_DATA_WIDTH-1:0] o_data;
  logic [3:0]              o_keep;
  logic                    o_last;
  logic                    o_valid;
  logic                    i_ready;
  logic                    o_overflow;
  logic                    o_proto_err;
  logic [15:0]             o_xfer_cnt;

  modport master (
    output packer_dout, packer_first_dw, packer_valid, packer_done, i_ready,
    input  o_data, o_keep, o_last, o_valid, o_overflow, o_proto_err, o_xfer_cnt
  );

  modport slave (
    input  packer_dout, packer_first_dw, packer_valid, packer_done, i_ready,
    output o_data, o_keep, o_last, o_valid, o_overflow, o_proto_err, o_xfer_cnt
  );
endinterface

// File: rtl/dma_rx_packer.sv
// ---------------------------------------------------------------------------
// dma_rx_packer
//   Compacts completion beats carrying 1-4 DWs into a gap-free stream of
//   128-bit words, tags the final word of each transfer, and queues the
//   words in a show-ahead FIFO. There is no backpressure towards the
//   endpoint: a full FIFO drops the word and raises a sticky overflow flag.
//
//   Ports:
//     i_clk    single rising-edge clock
//     i_rst_n  asynchronous active-low reset
//     bus      dma_rx_packer_if.slave (beat inputs, FIFO head outputs)
// ---------------------------------------------------------------------------
module dma_rx_packer #(
  parameter int P_DATA_WIDTH = 128,
  parameter int P_FIFO_DEPTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  dma_rx_packer_if.slave bus
);

  localparam int LP_PTR_W = $clog2(P_FIFO_DEPTH);
  localparam int LP_CNT_W = LP_PTR_W + 1;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t                  r_state;
  state_t                  w_stateNext;

  // Residual DWs live in r_res[0 .. r_resCnt-1]; higher slots are kept zero.
  logic [31:0]             r_res [3];
  logic [1:0]              r_resCnt;
  logic [31:0]             w_resNext [3];
  logic [1:0]              w_resCntNext;

  logic [31:0]             w_merged [7];
  logic [2:0]              w_beatCnt;
  logic [2:0]              w_total;

  logic                    w_push;
  logic [P_DATA_WIDTH-1:0] w_pushData;
  logic [3:0]              w_pushKeep;
  logic                    w_pushLast;
  logic                    w_xferInc;
  logic                    w_protoErr;

  logic [15:0]             r_xferCnt;
  logic                    r_protoErr;
  logic                    r_overflow;

  logic [P_DATA_WIDTH-1:0] r_memData [P_FIFO_DEPTH];
  logic [3:0]              r_memKeep [P_FIFO_DEPTH];
  logic                    r_memLast [P_FIFO_DEPTH];
  logic [LP_PTR_W-1:0]     r_wrPtr;
  logic [LP_PTR_W-1:0]     r_rdPtr;
  logic [LP_CNT_W-1:0]     r_count;
  logic                    w_notEmpty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_wrEn;

  // Line up the residual DWs followed by the beat's valid lanes in one
  // 7-entry array; entries past the total stay zero so leftovers are clean.
  always_comb begin
    w_beatCnt = 3'd4 - {1'b0, bus.packer_first_dw};
    w_total   = {1'b0, r_resCnt} + w_beatCnt;
    for (int i = 0; i < 7; i++) begin
      w_merged[i] = '0;
      for (int k = 0; k < 4; k++) begin
        if (k >= int'(bus.packer_first_dw) &&
            i == int'(r_resCnt) + k - int'(bus.packer_first_dw))
          w_merged[i] = bus.packer_dout[32*k +: 32];
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (i < int'(r_resCnt))
        w_merged[i] = r_res[i];
    end
  end

  // Next-state and push decision. A done beat whose DWs do not end exactly
  // on a word boundary leaves a residual that FLUSH emits one cycle later;
  // a beat arriving during that flush cycle is discarded and flagged.
  always_comb begin
    w_stateNext  = r_state;
    w_resCntNext = r_resCnt;
    for (int i = 0; i < 3; i++) w_resNext[i] = r_res[i];
    w_push       = 1'b0;
    w_pushData   = '0;
    w_pushKeep   = 4'h0;
    w_pushLast   = 1'b0;
    w_xferInc    = 1'b0;
    w_protoErr   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.packer_valid) begin
          if (w_total >= 3'd4) begin
            w_push       = 1'b1;
            w_pushData   = {w_merged[3], w_merged[2], w_merged[1], w_merged[0]};
            w_pushKeep   = 4'hF;
            w_resCntNext = 2'(w_total - 3'd4);
            for (int i = 0; i < 3; i++) w_resNext[i] = w_merged[i+4];
            if (bus.packer_done) begin
              if (w_total == 3'd4) begin
                w_pushLast = 1'b1;
                w_xferInc  = 1'b1;
              end else begin
                w_stateNext = ST_FLUSH;
              end
            end
          end else begin
            w_resCntNext = w_total[1:0];
            for (int i = 0; i < 3; i++) w_resNext[i] = w_merged[i];
            if (bus.packer_done)
              w_stateNext = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        w_push     = 1'b1;
        for (int i = 0; i < 3; i++) begin
          if (i < int'(r_resCnt))
            w_pushData[32*i +: 32] = r_res[i];
        end
        w_pushKeep   = (4'd1 << r_resCnt) - 4'd1;
        w_pushLast   = 1'b1;
        w_xferInc    = 1'b1;
        w_resCntNext = 2'd0;
        for (int i = 0; i < 3; i++) w_resNext[i] = '0;
        w_protoErr   = bus.packer_valid;
        w_stateNext  = ST_RUN;
      end
      default: w_stateNext = ST_RUN;
    endcase
  end

  // Packer state: FSM, residual, transfer counter and protocol flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_RUN;
      r_resCnt   <= 2'd0;
      for (int i = 0; i < 3; i++) r_res[i] <= '0;
      r_xferCnt  <= 16'd0;
      r_protoErr <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_resCnt <= w_resCntNext;
      for (int i = 0; i < 3; i++) r_res[i] <= w_resNext[i];
      if (w_xferInc)
        r_xferCnt <= r_xferCnt + 16'd1;
      if (w_protoErr)
        r_protoErr <= 1'b1;
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO still takes the
  // push. An empty FIFO cannot pop, so a new word is never bypassed.
  assign w_notEmpty = (r_count != '0);
  assign w_full     = (r_count == LP_CNT_W'(P_FIFO_DEPTH));
  assign w_pop      = w_notEmpty && bus.i_ready;
  assign w_wrEn     = w_push && (!w_full || w_pop);

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wrEn)
        r_wrPtr <= r_wrPtr + LP_PTR_W'(1);
      if (w_pop)
        r_rdPtr <= r_rdPtr + LP_PTR_W'(1);
      case ({w_wrEn, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_W'(1);
        2'b01:   r_count <= r_count - LP_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wrEn)
        r_overflow <= 1'b1;
    end
  end

  // Storage array; contents need no reset because the head is gated by
  // occupancy, which reset clears.
  always_ff @(posedge i_clk) begin
    if (w_wrEn) begin
      r_memData[r_wrPtr] <= w_pushData;
      r_memKeep[r_wrPtr] <= w_pushKeep;
      r_memLast[r_wrPtr] <= w_pushLast;
    end
  end

  assign bus.o_valid     = w_notEmpty;
  assign bus.o_data      = w_notEmpty ? r_memData[r_rdPtr] : '0;
  assign bus.o_keep      = w_notEmpty ? r_memKeep[r_rdPtr] : 4'h0;
  assign bus.o_last      = w_notEmpty ? r_memLast[r_rdPtr] : 1'b0;
  assign bus.o_overflow  = r_overflow;
  assign bus.o_proto_err = r_protoErr;
  assign bus.o_xfer_cnt  = r_xferCnt;

endmodule

// File: tb/tb_dma_rx_packer.sv
// ---------------------------------------------------------------------------
// tb_dma_rx_packer
//   Self-checking bench for dma_rx_packer. A queue-based reference model
//   tracks pending DWs, expected FIFO words and sticky flags; directed
//   scenarios also compare against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_dma_rx_packer;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
  } word_t;

  logic i_clk;
  logic i_rst_n;

  dma_rx_packer_if #(.P_DATA_WIDTH(128)) bus ();

  dma_rx_packer #(
    .P_DATA_WIDTH (128),
    .P_FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  // Reference model state.
  logic [31:0] mRes[$];
  word_t       expQ[$];
  logic [15:0] mXfer;
  logic        mOvf;
  logic        mProto;
  logic        mFlushPend;

  int nChecks;
  int nFail;

  // Free-running clock.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic set_idle();
    bus.packer_valid    = 1'b0;
    bus.packer_done     = 1'b0;
    bus.packer_first_dw = 2'd0;
    bus.packer_dout     = '0;
  endtask

  // Transfer-level model: collect DWs, emit a word every four, flush the
  // leftover a cycle after done, and bound the FIFO at DEPTH entries.
  task automatic model_step();
    word_t w;
    bit    haveWord;
    logic [127:0] d;
    w = '0;
    haveWord = 1'b0;
    if (expQ.size() > 0 && bus.i_ready) void'(expQ.pop_front());
    if (mFlushPend) begin
      for (int i = 0; i < mRes.size(); i++) w.data[32*i +: 32] = mRes[i];
      w.keep = 4'((1 << mRes.size()) - 1);
      w.last = 1'b1;
      mRes.delete();
      haveWord = 1'b1;
      mXfer = mXfer + 16'd1;
      mFlushPend = 1'b0;
      if (bus.packer_valid) mProto = 1'b1;
    end else if (bus.packer_valid) begin
      d = bus.packer_dout;
      for (int k = int'(bus.packer_first_dw); k < 4; k++) mRes.push_back(d[32*k +: 32]);
      if (mRes.size() >= 4) begin
        w.data = {mRes[3], mRes[2], mRes[1], mRes[0]};
        w.keep = 4'hF;
        repeat (4) void'(mRes.pop_front());
        haveWord = 1'b1;
      end
      if (bus.packer_done) begin
        if (mRes.size() == 0) begin
          w.last = 1'b1;
          mXfer = mXfer + 16'd1;
        end else begin
          mFlushPend = 1'b1;
        end
      end
    end
    if (haveWord) begin
      if (expQ.size() < DEPTH) expQ.push_back(w);
      else mOvf = 1'b1;
    end
  endtask

  // Advance one clock with the current inputs; outputs are sampled 1ns later.
  task automatic tick();
    model_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] fdw, input logic [127:0] data, input logic done);
    bus.packer_valid    = 1'b1;
    bus.packer_first_dw = fdw;
    bus.packer_dout     = data;
    bus.packer_done     = done;
    tick();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    set_idle();
    bus.i_ready = 1'b0;
    mRes.delete();
    expQ.delete();
    mXfer = 16'd0;
    mOvf = 1'b0;
    mProto = 1'b0;
    mFlushPend = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    set_idle();
    bus.i_ready = 1'b0;
    #2;
    nChecks++;
    if ({bus.o_valid, bus.o_last, bus.o_keep, bus.o_overflow, bus.o_proto_err} !== 8'h00 ||
        bus.o_data !== 128'h0 || bus.o_xfer_cnt !== 16'h0) begin
      nFail++;
      $display("[TB] FAIL reset_outputs: valid=%b keep=%h last=%b ovf=%b perr=%b xfer=%h data=%h, expected all zero",
               bus.o_valid, bus.o_keep, bus.o_last, bus.o_overflow, bus.o_proto_err, bus.o_xfer_cnt, bus.o_data);
    end
    do_reset();
    tick();
    nChecks++;
    if (bus.o_valid !== 1'b0 || bus.o_xfer_cnt !== 16'h0) begin
      nFail++;
      $display("[TB] FAIL reset_release: valid=%b xfer=%h, expected 0 and 0", bus.o_valid, bus.o_xfer_cnt);
    end
  endtask

  task automatic test_single_dw();
    do_reset();
    beat(2'd3, {32'hA0A0A0A0, 96'h0}, 1'b1);
    set_idle();
    nChecks++;
    if (bus.o_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL single_dw_early: valid=%b, expected 0 one cycle after beat", bus.o_valid);
    end
    tick();
    nChecks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== 128'hA0A0A0A0 || bus.o_keep !== 4'b0001 ||
        bus.o_last !== 1'b1 || bus.o_xfer_cnt !== 16'd1) begin
      nFail++;
      $display("[TB] FAIL single_dw_word: valid=%b data=%h keep=%b last=%b xfer=%0d, expected 1 A0A0A0A0 0001 1 1",
               bus.o_valid, bus.o_data, bus.o_keep, bus.o_last, bus.o_xfer_cnt);
    end
  endtask

  task automatic test_eight_dw();
    logic [31:0] dw [8];
    do_reset();
    for (int k = 0; k < 8; k++) dw[k] = 32'h1000 + 32'(k);
    beat(2'd3, {dw[0], 96'h0}, 1'b0);
    beat(2'd0, {dw[4], dw[3], dw[2], dw[1]}, 1'b0);
    nChecks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== {dw[3], dw[2], dw[1], dw[0]} ||
        bus.o_keep !== 4'hF || bus.o_last !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL eight_dw_word0: valid=%b data=%h keep=%h last=%b, expected 1 %h F 0",
               bus.o_valid, bus.o_data, bus.o_keep, bus.o_last, {dw[3], dw[2], dw[1], dw[0]});
    end
    bus.i_ready = 1'b1;
    beat(2'd1, {dw[7], dw[6], dw[5], 32'h0}, 1'b1);
    set_idle();
    nChecks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== {dw[7], dw[6], dw[5], dw[4]} ||
        bus.o_keep !== 4'hF || bus.o_last !== 1'b1 || bus.o_xfer_cnt !== 16'd1) begin
      nFail++;
      $display("[TB] FAIL eight_dw_word1: valid=%b data=%h keep=%h last=%b xfer=%0d, expected 1 %h F 1 1",
               bus.o_valid, bus.o_data, bus.o_keep, bus.o_last, bus.o_xfer_cnt, {dw[7], dw[6], dw[5], dw[4]});
    end
    tick();
    nChecks++;
    if (bus.o_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL eight_dw_noflush: valid=%b, expected 0 (no flush word)", bus.o_valid);
    end
  endtask

  task automatic test_six_dw();
    logic [31:0] dw [6];
    do_reset();
    for (int k = 0; k < 6; k++) dw[k] = 32'h1000 + 32'(k);
    beat(2'd3, {dw[0], 96'h0}, 1'b0);
    beat(2'd0, {dw[4], dw[3], dw[2], dw[1]}, 1'b0);
    beat(2'd3, {dw[5], 96'h0}, 1'b1);
    set_idle();
    tick();
    nChecks++;
    if (bus.o_data !== {dw[3], dw[2], dw[1], dw[0]} || bus.o_keep !== 4'hF || bus.o_last !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL six_dw_word0: data=%h keep=%h last=%b, expected %h F 0",
               bus.o_data, bus.o_keep, bus.o_last, {dw[3], dw[2], dw[1], dw[0]});
    end
    bus.i_ready = 1'b1;
    tick();
    nChecks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== {64'h0, dw[5], dw[4]} || bus.o_keep !== 4'b0011 ||
        bus.o_last !== 1'b1 || bus.o_xfer_cnt !== 16'd1) begin
      nFail++;
      $display("[TB] FAIL six_dw_flush: valid=%b data=%h keep=%b last=%b xfer=%0d, expected 1 %h 0011 1 1",
               bus.o_valid, bus.o_data, bus.o_keep, bus.o_last, bus.o_xfer_cnt, {64'h0, dw[5], dw[4]});
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] words [9];
    do_reset();
    for (int i = 0; i < 9; i++) words[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 8; i++) beat(2'd0, words[i], 1'b0);
    nChecks++;
    if (bus.o_overflow !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL bp_exact_full: overflow=%b, expected 0 with 8 words", bus.o_overflow);
    end
    beat(2'd0, words[8], 1'b1);
    set_idle();
    nChecks++;
    if (bus.o_overflow !== 1'b1 || bus.o_xfer_cnt !== 16'd1) begin
      nFail++;
      $display("[TB] FAIL bp_overflow: overflow=%b xfer=%0d, expected 1 1", bus.o_overflow, bus.o_xfer_cnt);
    end
    bus.i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nChecks++;
      if (bus.o_valid !== 1'b1 || bus.o_data !== words[i] || bus.o_keep !== 4'hF || bus.o_last !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL bp_drain_%0d: valid=%b data=%h last=%b, expected 1 %h 0",
                 i, bus.o_valid, bus.o_data, bus.o_last, words[i]);
      end
      tick();
    end
    nChecks++;
    if (bus.o_valid !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL bp_word9_lost: valid=%b, expected 0 after 8 words", bus.o_valid);
    end
  endtask

  task automatic test_proto_err();
    do_reset();
    bus.i_ready = 1'b1;
    beat(2'd2, {32'hBBBB0003, 32'hBBBB0002, 64'h0}, 1'b1);
    beat(2'd0, {4{32'hDEADBEEF}}, 1'b0);
    set_idle();
    nChecks++;
    if (bus.o_proto_err !== 1'b1 || bus.o_valid !== 1'b1 ||
        bus.o_data !== {64'h0, 32'hBBBB0003, 32'hBBBB0002} || bus.o_keep !== 4'b0011 || bus.o_last !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL proto_err_flush: perr=%b valid=%b data=%h keep=%b last=%b, expected 1 1 %h 0011 1",
               bus.o_proto_err, bus.o_valid, bus.o_data, bus.o_keep, bus.o_last, {64'h0, 32'hBBBB0003, 32'hBBBB0002});
    end
    tick();
    nChecks++;
    if (bus.o_valid !== 1'b0 || bus.o_xfer_cnt !== 16'd1) begin
      nFail++;
      $display("[TB] FAIL proto_err_drop: valid=%b xfer=%0d, expected 0 1", bus.o_valid, bus.o_xfer_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) beat(2'd0, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    beat(2'd2, {32'h55, 32'h44, 64'h0}, 1'b0);
    set_idle();
    #2;
    i_rst_n = 1'b0;
    #1;
    nChecks++;
    if (bus.o_valid !== 1'b0 || bus.o_data !== 128'h0 || bus.o_keep !== 4'h0 || bus.o_xfer_cnt !== 16'h0) begin
      nFail++;
      $display("[TB] FAIL async_reset: valid=%b data=%h keep=%h xfer=%0d, expected all zero before any edge",
               bus.o_valid, bus.o_data, bus.o_keep, bus.o_xfer_cnt);
    end
    do_reset();
    bus.i_ready = 1'b1;
    beat(2'd0, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 1'b1);
    set_idle();
    nChecks++;
    if (bus.o_valid !== 1'b1 || bus.o_data !== {32'hC3, 32'hC2, 32'hC1, 32'hC0} ||
        bus.o_keep !== 4'hF || bus.o_last !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL async_reset_clean: valid=%b data=%h keep=%h last=%b, expected 1 %h F 1",
               bus.o_valid, bus.o_data, bus.o_keep, bus.o_last, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    end
    tick();
    nChecks++;
    if (bus.o_valid !== 1'b0 || bus.o_xfer_cnt !== 16'd1) begin
      nFail++;
      $display("[TB] FAIL async_reset_single: valid=%b xfer=%0d, expected 0 1", bus.o_valid, bus.o_xfer_cnt);
    end
  endtask

  // Random beats, random dones (with the required idle cycle) and random
  // stalls, compared against the model every cycle. readyPct controls how
  // often the sink accepts, so a low value exercises overflow.
  task automatic test_random(input int cycles, input int readyPct);
    bit mustIdle;
    do_reset();
    mustIdle = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      bus.i_ready = ($urandom_range(0, 99) < readyPct);
      if (!mustIdle && $urandom_range(0, 3) != 0) begin
        bus.packer_valid    = 1'b1;
        bus.packer_first_dw = 2'($urandom_range(0, 3));
        bus.packer_dout     = {$urandom, $urandom, $urandom, $urandom};
        bus.packer_done     = ($urandom_range(0, 4) == 0);
      end else begin
        set_idle();
      end
      mustIdle = bus.packer_valid && bus.packer_done;
      tick();
      nChecks++;
      if (expQ.size() > 0) begin
        if (bus.o_valid !== 1'b1 || bus.o_data !== expQ[0].data ||
            bus.o_keep !== expQ[0].keep || bus.o_last !== expQ[0].last) begin
          nFail++;
          $display("[TB] FAIL random_head c=%0d: valid=%b data=%h keep=%h last=%b, expected 1 %h %h %b",
                   c, bus.o_valid, bus.o_data, bus.o_keep, bus.o_last, expQ[0].data, expQ[0].keep, expQ[0].last);
        end
      end else if (bus.o_valid !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL random_empty c=%0d: valid=%b, expected 0", c, bus.o_valid);
      end
      nChecks++;
      if (bus.o_xfer_cnt !== mXfer || bus.o_overflow !== mOvf || bus.o_proto_err !== mProto) begin
        nFail++;
        $display("[TB] FAIL random_status c=%0d: xfer=%0d ovf=%b perr=%b, expected %0d %b %b",
                 c, bus.o_xfer_cnt, bus.o_overflow, bus.o_proto_err, mXfer, mOvf, mProto);
      end
    end
    set_idle();
  endtask

  initial begin
    nChecks = 0;
    nFail   = 0;
    test_reset();
    test_single_dw();
    test_eight_dw();
    test_six_dw();
    test_backpressure();
    test_proto_err();
    test_async_reset();
    test_random(400, 80);
    test_random(300, 25);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
